machine_timer_unit: RTL

//  Memory-mapped RISC-V machine timer (mtime/mtimecmp) on the data-memory bus.

---
 rtl/riscV_unrn_pkg.sv | 21 ++
 rtl/machine_timer_unit_mtime_counter.sv | 37 +++
 rtl/machine_timer_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/riscV_unrn_pkg.sv
// Shared core definitions: timer bus addresses, timer word selector, interrupt cause.
package riscV_unrn_pkg;

  localparam logic [31:0] MTIME_MEM_ADDRESS_LOW     = 32'h0000_8004;
  localparam logic [31:0] MTIME_MEM_ADDRESS_HIGH    = 32'h0000_8008;
  localparam logic [31:0] MTIMECMP_MEM_ADDRESS_LOW  = 32'h0000_800C;
  localparam logic [31:0] MTIMECMP_MEM_ADDRESS_HIGH = 32'h0000_8010;

  typedef enum logic [1:0] {
    MTIME_LOW,
    MTIME_HIGH,
    MTIMECMP_LOW,
    MTIMECMP_HIGH
  } mtime_address_t;

  // mcause value for a machine timer interrupt (interrupt bit + code 7)
  localparam logic [31:0] M_TIMER_INT = 32'h8000_0007;

  localparam logic [63:0] MTIMECMP_RESET_VAL = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/machine_timer_unit_mtime_counter.sv
// Prescaled 64-bit free-running mtime counter with 32-bit half loads.
// A load in a tick cycle wins: the tick is dropped, no carry into the other half.
module mtime_counter #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mtime <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (load_lo)
        mtime[31:0] <= wdata;
      else if (load_hi)
        mtime[63:32] <= wdata;
      else if (tick)
        mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/machine_timer_unit.sv
// Memory-mapped RISC-V machine timer: mtime/mtimecmp words, read port, mtip level.
// Optional MTIMER_SNAPSHOT_EN: LOW reads latch mtime[63:32] so a following HIGH read is atomic.
module machine_timer_unit
  import riscV_unrn_pkg::*;
#(
  parameter int          PRESCALE  = 1,
  parameter logic [63:0] CMP_RESET = MTIMECMP_RESET_VAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic        hit_o,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        mtip_o,
  output logic [63:0] mtime_o
);

  mtime_address_t sel;
  logic [63:0]    mtimecmp;
  logic [63:0]    mtime;
  logic [31:0]    rd_val;
  logic           wr_en;
  logic           rd_en;

  always_comb begin
    hit_o = 1'b1;
    sel   = MTIME_LOW;
    case (addr_i)
      MTIME_MEM_ADDRESS_LOW:     sel = MTIME_LOW;
      MTIME_MEM_ADDRESS_HIGH:    sel = MTIME_HIGH;
      MTIMECMP_MEM_ADDRESS_LOW:  sel = MTIMECMP_LOW;
      MTIMECMP_MEM_ADDRESS_HIGH: sel = MTIMECMP_HIGH;
      default:                   hit_o = 1'b0;
    endcase
  end

  assign wr_en = we_i & hit_o;
  assign rd_en = re_i & hit_o;

  mtime_counter #(.PRESCALE(PRESCALE)) u_counter (
    .clk     (clk),
    .rst     (rst),
    .load_lo (wr_en && (sel == MTIME_LOW)),
    .load_hi (wr_en && (sel == MTIME_HIGH)),
    .wdata   (wdata_i),
    .mtime   (mtime)
  );

  assign mtime_o = mtime;

`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0] shadow;

  always_ff @(posedge clk) begin
    if (rst)
      shadow <= '0;
    else if (rd_en && (sel == MTIME_LOW))
      shadow <= mtime[63:32];
    else if (wr_en && (sel == MTIME_HIGH))
      shadow <= wdata_i;
  end
`endif

  // Read mux sees only current register values, giving read-old on a same-cycle write
  always_comb begin
    rd_val = '0;
    case (sel)
      MTIME_LOW:     rd_val = mtime[31:0];
`ifdef MTIMER_SNAPSHOT_EN
      MTIME_HIGH:    rd_val = shadow;
`else
      MTIME_HIGH:    rd_val = mtime[63:32];
`endif
      MTIMECMP_LOW:  rd_val = mtimecmp[31:0];
      MTIMECMP_HIGH: rd_val = mtimecmp[63:32];
      default:       rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= CMP_RESET;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      mtip_o   <= 1'b0;
    end else begin
      rvalid_o <= rd_en;
      if (rd_en)
        rdata_o <= rd_val;
      if (wr_en && (sel == MTIMECMP_LOW))
        mtimecmp[31:0] <= wdata_i;
      if (wr_en && (sel == MTIMECMP_HIGH))
        mtimecmp[63:32] <= wdata_i;
      mtip_o <= (mtime >= mtimecmp);
    end
  end

endmodule
